// File: rtl/controller_pad_responder.sv
// controller_pad_responder
// Pad side of the serial gamepad link. The controller reader raises the latch
// to capture 8 button levels, then clocks them out one bit per link-clock
// rising edge. The data line is active-low: 0 means pressed.
// Link pins are asynchronous and are synchronised before use.
module controller_pad_responder #(
   parameter logic        MSB_FIRST = 1'b1,
   parameter logic        FILL_BIT  = 1'b0,
   parameter logic [15:0] TIMEOUT   = 16'd1024
) (
   input  logic       clk_12_5875,
   input  logic       rst_n,
   input  logic [7:0] buttons_in,
   input  logic       controller_clk_in,
   input  logic       controller_latch_in,
   output logic       controller_data_out_B,
   output logic       busy,
   output logic [3:0] bits_sent,
   output logic       frame_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Bit currently at the output end of the shift register.
   function automatic logic out_bit(input logic [7:0] sr);
      if (MSB_FIRST) begin
         out_bit = sr[7];
      end else begin
         out_bit = sr[0];
      end
   endfunction

   // One shift toward the output end, with the fill value entering behind.
   function automatic logic [7:0] shift_fill(input logic [7:0] sr);
      if (MSB_FIRST) begin
         shift_fill = {sr[6:0], FILL_BIT};
      end else begin
         shift_fill = {FILL_BIT, sr[7:1]};
      end
   endfunction

   logic [2:0]  clk_sync_r;
   logic [2:0]  latch_sync_r;
   logic [1:0]  state_r;
   logic [1:0]  state_s;
   logic [7:0]  shift_r;
   logic [7:0]  shift_s;
   logic [3:0]  cnt_r;
   logic [3:0]  cnt_s;
   logic [15:0] tmo_r;
   logic [15:0] tmo_s;
   logic        data_b_r;
   logic        data_b_s;
   logic        busy_r;
   logic        busy_s;
   logic        done_r;
   logic        done_s;
   logic        clk_rise_s;
   logic        latch_fall_s;
   logic        latch_hi_s;

   // Two-flop synchronisers plus a third stage for edge detection.
   always_ff @(posedge clk_12_5875) begin
      if (!rst_n) begin
         clk_sync_r   <= 3'b000;
         latch_sync_r <= 3'b000;
      end else begin
         clk_sync_r   <= {clk_sync_r[1:0], controller_clk_in};
         latch_sync_r <= {latch_sync_r[1:0], controller_latch_in};
      end
   end

   assign clk_rise_s   = clk_sync_r[1] & ~clk_sync_r[2];
   assign latch_fall_s = ~latch_sync_r[1] & latch_sync_r[2];
   assign latch_hi_s   = latch_sync_r[1];

   // Frame FSM. A latch seen in SHIFT or DONE wins over a coincident link-clock edge.
   always_comb begin
      state_s = state_r;
      shift_s = shift_r;
      cnt_s   = cnt_r;
      tmo_s   = tmo_r;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (latch_hi_s) begin
               state_s = ST_LOAD;
               shift_s = buttons_in;
               cnt_s   = 4'd0;
               tmo_s   = 16'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            cnt_s = 4'd0;
            tmo_s = 16'd0;
            // Reload live while latch is high. The value from the last high cycle is kept.
            if (latch_hi_s) begin
               shift_s = buttons_in;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (latch_hi_s) begin
               state_s = ST_LOAD;
               shift_s = buttons_in;
               cnt_s   = 4'd0;
               tmo_s   = 16'd0;
            end else if (clk_rise_s && !latch_fall_s) begin
               shift_s = shift_fill(shift_r);
               cnt_s   = cnt_r + 4'd1;
               tmo_s   = 16'd0;
               if (cnt_r == 4'd7) begin
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s = ST_SHIFT;
               end
            end else if (tmo_r >= (TIMEOUT - 16'd1)) begin
               // The link stalled mid-frame, so drop the frame silently.
               state_s = ST_IDLE;
               tmo_s   = 16'd0;
            end else begin
               tmo_s = tmo_r + 16'd1;
            end
         end
         ST_DONE: begin
            if (latch_hi_s) begin
               state_s = ST_LOAD;
               shift_s = buttons_in;
               cnt_s   = 4'd0;
               tmo_s   = 16'd0;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output data follows the current state and register, giving one register stage after load/shift.
   always_comb begin
      data_b_s = 1'b1;
      case (state_r)
         ST_LOAD:  data_b_s = ~out_bit(shift_r);
         ST_SHIFT: data_b_s = ~out_bit(shift_r);
         ST_DONE:  data_b_s = ~FILL_BIT;
         default:  data_b_s = 1'b1;
      endcase
      busy_s = (state_s == ST_LOAD) || (state_s == ST_SHIFT);
   end

   // State and registered outputs.
   always_ff @(posedge clk_12_5875) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         shift_r  <= 8'd0;
         cnt_r    <= 4'd0;
         tmo_r    <= 16'd0;
         data_b_r <= 1'b1;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         shift_r  <= shift_s;
         cnt_r    <= cnt_s;
         tmo_r    <= tmo_s;
         data_b_r <= data_b_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   assign controller_data_out_B = data_b_r;
   assign busy                  = busy_r;
   assign bits_sent             = cnt_r;
   assign frame_done            = done_r;

endmodule

// File: tb/tb_controller_pad_responder.sv
// Bench for controller_pad_responder. It runs two instances side by side:
// one sends the MSB first and the other sends the LSB first. The stimulus
// side pushes hand-computed serial bits into queues. A negedge monitor pops
// each bit and compares it with the data line whenever the reader samples.
module tb_controller_pad_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] buttons_in;
   logic       link_clk;
   logic       link_latch;
   logic       data_m, busy_m, fd_m;
   logic [3:0] bits_m;
   logic       data_l, busy_l, fd_l;
   logic [3:0] bits_l;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_m_cnt = 0;
   int fd_l_cnt = 0;
   bit exp_m_q[$];
   bit exp_l_q[$];
   logic sample_s = 1'b0;

   controller_pad_responder #(.MSB_FIRST(1'b1), .FILL_BIT(1'b0), .TIMEOUT(16'd1024)) dut_m (
      .clk_12_5875(clk), .rst_n(rst_n), .buttons_in(buttons_in),
      .controller_clk_in(link_clk), .controller_latch_in(link_latch),
      .controller_data_out_B(data_m), .busy(busy_m), .bits_sent(bits_m), .frame_done(fd_m));

   controller_pad_responder #(.MSB_FIRST(1'b0), .FILL_BIT(1'b0), .TIMEOUT(16'd1024)) dut_l (
      .clk_12_5875(clk), .rst_n(rst_n), .buttons_in(buttons_in),
      .controller_clk_in(link_clk), .controller_latch_in(link_latch),
      .controller_data_out_B(data_l), .busy(busy_l), .bits_sent(bits_l), .frame_done(fd_l));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: count frame_done pulses and score the serial bits at each reader sample.
   always @(negedge clk) begin
      if (fd_m === 1'b1) fd_m_cnt++;
      if (fd_l === 1'b1) fd_l_cnt++;
      if (sample_s) begin
         if (exp_m_q.size() == 0 || exp_l_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sample_without_expectation at %0t", $time);
         end else begin
            check("serial_msb", {31'd0, data_m}, {31'd0, exp_m_q.pop_front()});
            check("serial_lsb", {31'd0, data_l}, {31'd0, exp_l_q.pop_front()});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sequence byte holds the data_B levels in send order, first bit in [7]. Past bit 8 only fill shows.
   function automatic bit bit_of(input logic [7:0] seq, input int i);
      if (i < 8) return seq[7 - i];
      else return 1'b1;
   endfunction

   task automatic push(input logic [7:0] seq_m, input logic [7:0] seq_l, input int i);
      exp_m_q.push_back(bit_of(seq_m, i));
      exp_l_q.push_back(bit_of(seq_l, i));
      sample_s = 1'b1;
      tick(1);
      sample_s = 1'b0;
   endtask

   task automatic latch_phase(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      buttons_in = b0;
      link_latch = 1'b1;
      tick(3);
      buttons_in = b1;
      tick(4);
      link_latch = 1'b0;
      tick(4);
      buttons_in = b2;
      tick(2);
   endtask

   task automatic clock_phase(input int n, input logic [7:0] seq_m, input logic [7:0] seq_l);
      push(seq_m, seq_l, 0);
      for (int i = 1; i <= n; i++) begin
         link_clk = 1'b1;
         tick(6);
         link_clk = 1'b0;
         push(seq_m, seq_l, i);
         tick(5);
      end
   endtask

   task automatic frame_end(input string name, input int fd_m0, input int fd_l0);
      tick(8);
      check({name, "_bits_msb"}, {28'd0, bits_m}, 32'd8);
      check({name, "_bits_lsb"}, {28'd0, bits_l}, 32'd8);
      check({name, "_busy"}, {30'd0, busy_m, busy_l}, 32'd0);
      check({name, "_data_idle"}, {30'd0, data_m, data_l}, 32'd3);
      check({name, "_fd_msb"}, fd_m_cnt - fd_m0, 32'd1);
      check({name, "_fd_lsb"}, fd_l_cnt - fd_l0, 32'd1);
   endtask

   initial begin
      int fm0;
      int fl0;
      // Reset with random pins
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         buttons_in = 8'($urandom);
         link_clk   = 1'($urandom);
         link_latch = 1'($urandom);
         tick(1);
      end
      check("rst_data", {30'd0, data_m, data_l}, 32'd3);
      check("rst_busy", {30'd0, busy_m, busy_l}, 32'd0);
      check("rst_bits", {24'd0, bits_m, bits_l}, 32'd0);
      buttons_in = 8'h00;
      link_clk   = 1'b0;
      link_latch = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(3);
      check("rst_no_frame_done", fd_m_cnt + fd_l_cnt, 32'd0);

      // Frame 8'h7F
      fm0 = fd_m_cnt; fl0 = fd_l_cnt;
      latch_phase(8'h7F, 8'h7F, 8'h7F);
      clock_phase(8, 8'b1000_0000, 8'b0000_0001);
      frame_end("frame_7f", fm0, fl0);

      // LSB order with 8'hFE
      fm0 = fd_m_cnt; fl0 = fd_l_cnt;
      latch_phase(8'hFE, 8'hFE, 8'hFE);
      clock_phase(8, 8'b0000_0001, 8'b1000_0000);
      frame_end("frame_fe", fm0, fl0);

      // Live reload: 00 -> A5 while latch is high, FF after it falls
      fm0 = fd_m_cnt; fl0 = fd_l_cnt;
      latch_phase(8'h00, 8'hA5, 8'hFF);
      clock_phase(8, 8'b0101_1010, 8'b0101_1010);
      frame_end("live_a5", fm0, fl0);

      // Overrun: 12 clocks, fill afterwards
      fm0 = fd_m_cnt; fl0 = fd_l_cnt;
      latch_phase(8'h3C, 8'h3C, 8'h3C);
      clock_phase(12, 8'b1100_0011, 8'b1100_0011);
      frame_end("overrun", fm0, fl0);

      // Abort: stall after 3 clocks
      fm0 = fd_m_cnt; fl0 = fd_l_cnt;
      latch_phase(8'h5A, 8'h5A, 8'h5A);
      clock_phase(3, 8'b1010_0101, 8'b1010_0101);
      tick(1028);
      check("abort_busy", {30'd0, busy_m, busy_l}, 32'd0);
      check("abort_data", {30'd0, data_m, data_l}, 32'd3);
      check("abort_no_fd", (fd_m_cnt - fm0) + (fd_l_cnt - fl0), 32'd0);

      // Latch coincident with the 8th clock edge: reload wins, no shift, no frame_done
      latch_phase(8'hC3, 8'hC3, 8'hC3);
      clock_phase(7, 8'b0011_1100, 8'b0011_1100);
      check("pre_coinc_bits", {24'd0, bits_m, bits_l}, 32'h77);
      fm0 = fd_m_cnt; fl0 = fd_l_cnt;
      buttons_in = 8'h81;
      link_latch = 1'b1;
      link_clk   = 1'b1;
      tick(5);
      check("coinc_bits", {24'd0, bits_m, bits_l}, 32'd0);
      check("coinc_busy", {30'd0, busy_m, busy_l}, 32'd3);
      check("coinc_no_fd", (fd_m_cnt - fm0) + (fd_l_cnt - fl0), 32'd0);
      tick(2);
      link_latch = 1'b0;
      link_clk   = 1'b0;
      tick(6);
      clock_phase(8, 8'b0111_1110, 8'b0111_1110);
      frame_end("after_coinc", fm0, fl0);

      tick(3);
      check("queue_drain", exp_m_q.size() + exp_l_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
